// File: rtl/bmp_loader_pkg.sv
// rtl/bmp_loader_pkg.sv - shared bitmap geometry and loader state encoding
package bmp_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BMP_W  = 1536;
  localparam int NWORDS = BMP_W / WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_LOAD,
    ST_RUN,
    ST_FIN
  } state_t;

endpackage

// File: rtl/bmp_loader_assembler.sv
// rtl/bmp_loader_assembler.sv - bitmap word-assembly register
// Module name bmp_assembler: indexed word write, full-width hold otherwise.
module bmp_assembler #(
  parameter int WORD_W = bmp_loader_pkg::WORD_W,
  parameter int BMP_W  = bmp_loader_pkg::BMP_W,
  parameter int NWORDS = bmp_loader_pkg::NWORDS,
  parameter int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [CW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [BMP_W-1:0]  o_bitmap
);

  logic [BMP_W-1:0] r_bitmap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitmap <= '0;
    end else if (i_we) begin
      r_bitmap[WORD_W*int'(i_idx) +: WORD_W] <= i_wdata;
    end
  end

  assign o_bitmap = r_bitmap;

endmodule

// File: rtl/bmp_loader.sv
// rtl/bmp_loader.sv - fetches a bitmap word by word, hands it to the compare
// accelerator and captures the accelerator result.
module bmp_loader #(
  parameter int WORD_W = bmp_loader_pkg::WORD_W,
  parameter int BMP_W  = bmp_loader_pkg::BMP_W,
  parameter int NWORDS = BMP_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       base_addr,
  output logic              mem_rd,
  output logic [15:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [BMP_W-1:0]  bitmap,
  output logic              wren,
  input  logic              acc_done,
  input  logic [15:0]       acc_result,
  output logic [15:0]       result,
  output logic              busy,
  output logic              done
);

  import bmp_loader_pkg::*;

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_base;
  logic [15:0]     r_mem_addr;
  logic [15:0]     r_result;
  logic            r_mem_rd;
  logic            r_wren;
  logic            r_done;
  logic            r_busy;

  logic            w_last;
  logic            w_word_we;
  logic [CW-1:0]   w_next_count;
  logic [15:0]     w_next_addr;

  assign w_last       = (r_count == CW'(NWORDS - 1));
  assign w_word_we    = (r_state == ST_WAIT) && mem_rvalid;
  assign w_next_count = r_count + 1'b1;
  assign w_next_addr  = r_base + 16'(w_next_count);

  // mem_rd is raised on entry to REQ so it is high exactly while in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_result   <= '0;
      r_mem_rd   <= 1'b0;
      r_wren     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_wren   <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_count    <= '0;
            r_mem_addr <= base_addr;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (w_last) begin
              r_wren  <= 1'b1;
              r_state <= ST_LOAD;
            end else begin
              r_count    <= w_next_count;
              r_mem_addr <= w_next_addr;
              r_mem_rd   <= 1'b1;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (acc_done) begin
            r_result <= acc_result;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  bmp_assembler #(
    .WORD_W (WORD_W),
    .BMP_W  (BMP_W),
    .NWORDS (NWORDS),
    .CW     (CW)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_word_we),
    .i_idx    (r_count),
    .i_wdata  (mem_rdata),
    .o_bitmap (bitmap)
  );

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign wren     = r_wren;
  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
